// File: rtl/cpu_ctrl_fsm.sv
// Instruction sequencer for the register-file/shifter/ALU datapath.
// Optional illegal-instruction trap state is enabled by defining CTRL_ILLEGAL_TRAP_EN.
module cpu_ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic        done,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic [15:0] sximm8,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic [1:0]  shift,
  output logic [1:0]  ALU_op
);

  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    GET_A,
    GET_B,
    EXEC,
    WR_REG,
`ifdef CTRL_ILLEGAL_TRAP_EN
    WR_IMM,
    ERR
`else
    WR_IMM
`endif
  } state_t;

  state_t      state, next_state;
  logic [15:0] ir;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_alu, is_mov_imm, is_mov_reg, is_cmp, is_mvn;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign is_alu     = (opcode == 3'b101);
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  // ir only loads on an accepted start, so it is stable for the whole instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
      ir    <= 16'h0000;
    end else begin
      state <= next_state;
      if (state == WAIT && s)
        ir <= instr;
    end
  end

  always_comb begin
    next_state = state;
    w        = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    shift    = 2'b00;
    ALU_op   = 2'b00;

    case (state)
      WAIT: begin
        w = 1'b1;
        if (s)
          next_state = DECODE;
      end
      DECODE: begin
        if (is_mov_imm)
          next_state = WR_IMM;
        else if (is_alu && !is_mvn)
          next_state = GET_A;
        else if (is_mvn || is_mov_reg)
          next_state = GET_B;
        else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          next_state = ERR;
`else
          done       = 1'b1;
          next_state = WAIT;
`endif
        end
      end
      GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        next_state = GET_B;
      end
      GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        next_state = EXEC;
      end
      // MOV reg passes Rm through the shifter and adds it to a forced-zero A
      EXEC: begin
        shift = sh;
        if (is_alu)
          ALU_op = op;
        else
          asel = 1'b1;
        if (is_cmp) begin
          loads      = 1'b1;
          done       = 1'b1;
          next_state = WAIT;
        end else begin
          loadc      = 1'b1;
          next_state = WR_REG;
        end
      end
      WR_REG: begin
        writenum   = rd;
        write      = 1'b1;
        done       = 1'b1;
        next_state = WAIT;
      end
      WR_IMM: begin
        writenum   = rn;
        vsel       = 1'b1;
        write      = 1'b1;
        done       = 1'b1;
        next_state = WAIT;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      ERR: begin
        err        = 1'b1;
        next_state = ERR;
      end
`endif
      default: next_state = WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard testbench for cpu_ctrl_fsm: expected per-cycle outputs are queued
// when an instruction is driven and compared each falling clock edge.
module tb_cpu_ctrl_fsm;

  typedef struct packed {
    logic        w;
    logic        done;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic [15:0] sximm8;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  shift;
    logic [1:0]  alu_op;
  } out_t;

  typedef struct {
    string tag;
    out_t  v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s;
  logic [15:0] instr;
  logic        w, done, err, write, vsel, loada, loadb, loadc, loads, asel;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm8;
  logic [1:0]  shift, ALU_op;
  logic [35:0] dut_vec;

  exp_t expq[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  cpu_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .s(s), .instr(instr),
    .w(w), .done(done), .err(err),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .sximm8(sximm8), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .shift(shift), .ALU_op(ALU_op)
  );

  always #5 clk = ~clk;

  assign dut_vec = {w, done, err, readnum, writenum, write, vsel, sximm8,
                    loada, loadb, loadc, loads, asel, shift, ALU_op};

  task automatic checkOutput(input string tag, input logic [35:0] act, input logic [35:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, expv);
    end
  endtask

  function automatic out_t baseOut(input logic [15:0] ins);
    out_t o;
    o = '0;
    o.sximm8 = {{8{ins[7]}}, ins[7:0]};
    return o;
  endfunction

  // Independent per-cycle model of one instruction, from DECODE through the WAIT after it
  function automatic void pushExpected(input logic [15:0] ins, input int keep);
    exp_t seq[$];
    out_t o, b;
    logic [2:0] opc;
    logic [1:0] op;
    logic alu, movi, movr, cmp;
    opc  = ins[15:13];
    op   = ins[12:11];
    alu  = (opc == 3'b101);
    movi = (opc == 3'b110) && (op == 2'b10);
    movr = (opc == 3'b110) && (op == 2'b00);
    cmp  = alu && (op == 2'b01);
    b    = baseOut(ins);

    o = b;
`ifndef CTRL_ILLEGAL_TRAP_EN
    if (!(alu || movi || movr)) o.done = 1'b1;
`endif
    seq.push_back(exp_t'{"decode", o});
    if (movi) begin
      o = b; o.writenum = ins[10:8]; o.vsel = 1'b1; o.write = 1'b1; o.done = 1'b1;
      seq.push_back(exp_t'{"wr_imm", o});
    end else if (alu || movr) begin
      if (alu && op != 2'b11) begin
        o = b; o.readnum = ins[10:8]; o.loada = 1'b1;
        seq.push_back(exp_t'{"get_a", o});
      end
      o = b; o.readnum = ins[2:0]; o.loadb = 1'b1;
      seq.push_back(exp_t'{"get_b", o});
      o = b; o.shift = ins[4:3];
      if (alu) o.alu_op = op; else o.asel = 1'b1;
      if (cmp) begin o.loads = 1'b1; o.done = 1'b1; end
      else o.loadc = 1'b1;
      seq.push_back(exp_t'{"exec", o});
      if (!cmp) begin
        o = b; o.writenum = ins[7:5]; o.write = 1'b1; o.done = 1'b1;
        seq.push_back(exp_t'{"wr_reg", o});
      end
    end
    o = b; o.w = 1'b1;
    seq.push_back(exp_t'{"wait", o});
    for (int i = 0; i < seq.size() && i < keep; i++)
      expq.push_back(seq[i]);
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      cur = expq.pop_front();
      checkOutput(cur.tag, dut_vec, cur.v);
    end
  end

  task automatic drainQueue();
    int budget = 60;
    while (expq.size() > 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (expq.size() > 0) begin
      checkOutput("timeout", 36'(expq.size()), 36'd0);
      expq.delete();
    end
  endtask

  // Called just after a falling edge with the DUT in WAIT; junk on instr afterwards must be ignored
  task automatic applyStimulus(input logic [15:0] ins, input logic hold_s, input int keep);
    s     = 1'b1;
    instr = ins;
    pushExpected(ins, keep);
    @(posedge clk);
    #1;
    if (!hold_s) s = 1'b0;
    instr = ~ins;
    drainQueue();
  endtask

  logic [4:0]  legal [6] = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};
  logic [15:0] rnd;
  out_t        rst_exp;

  initial begin
    rst_exp   = baseOut(16'h0000);
    rst_exp.w = 1'b1;
    rst_n = 1'b1;
    s     = 1'b0;
    instr = 16'h0000;
    #1 rst_n = 1'b0;
    #1 checkOutput("reset", dut_vec, rst_exp);
    #5 rst_n = 1'b1;
    @(negedge clk);
    #1;

    applyStimulus(16'hD3FE, 1'b0, 99);
    applyStimulus(16'hA148, 1'b0, 99);
    applyStimulus(16'hAD06, 1'b0, 99);
    applyStimulus(16'hB887, 1'b1, 99);
    applyStimulus(16'hC022, 1'b0, 99);

    // Abort an ADD in GET_B: only DECODE and GET_A are expected before the reset
    applyStimulus(16'hA148, 1'b0, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_mid_get_b", dut_vec, rst_exp);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1 checkOutput("rst_after", dut_vec, rst_exp);
    applyStimulus(16'hA148, 1'b0, 99);

    for (int i = 0; i < 6; i++) begin
      rnd        = 16'($urandom);
      rnd[15:11] = legal[$urandom_range(0, 5)];
      applyStimulus(rnd, (i % 2 == 1) && (i < 5), 99);
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    begin
      out_t e;
      s     = 1'b1;
      instr = 16'h0000;
      pushExpected(16'h0000, 1);
      e     = baseOut(16'h0000);
      e.err = 1'b1;
      for (int i = 0; i < 20; i++) expq.push_back(exp_t'{"err_hold", e});
      for (int i = 0; i < 21; i++) begin
        @(posedge clk);
        #1 s = ~s;
      end
      drainQueue();
      rst_n = 1'b0;
      #1 checkOutput("err_cleared", dut_vec, rst_exp);
      #1 rst_n = 1'b1;
      s = 1'b0;
    end
`else
    applyStimulus(16'h0000, 1'b0, 99);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
